// File: rtl/slink_pkg.sv
// slink_pkg: constants, FSM encoding and CRC parameters shared by the SLINK receive checker.
package slink_pkg;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_SEED     = 16'hFFFF;
    localparam int          OFS_TICK     = 0;
    localparam int          OFS_LEN      = 1;
    localparam logic [8:0]  PKT_OVERHEAD = 9'd4;
    typedef enum logic [1:0] {ST_IDLE, ST_TICK, ST_LEN, ST_BODY} state_t;
endpackage

// File: rtl/slink_crc16.sv
// slink_crc16: combinational CRC-16/CCITT update for one byte, MSB first.
module slink_crc16
    import slink_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);
    always_comb begin
        crc_out = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++)
            crc_out = crc_out[15] ? ({crc_out[14:0], 1'b0} ^ CRC_POLY) : {crc_out[14:0], 1'b0};
    end
endmodule

// File: rtl/slink_pkt_check.sv
// slink_pkt_check: per-channel SLINK RX packet checker producing per-packet length/tick/CRC
// verdicts plus the SOP-gap based delay and link-break levels.
module slink_pkt_check
    import slink_pkg::*;
#(
    parameter logic [23:0] BREAK_TIMEOUT = 24'd1_250_000,
    parameter logic [23:0] DELAY_MAX     = 24'd125_000,
    parameter logic [15:0] CRC_INIT      = CRC_SEED
) (
    input  logic       clk_125m,
    input  logic       rst_125m,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_sop,
    input  logic       rx_eop,
    output logic       chn_pkt_eop,
    output logic       chn_pkt_len_err,
    output logic       chn_pkt_tick_err,
    output logic       chn_pkt_crc_err,
    output logic       chn_pkt_delay_err,
    output logic       chn_break_err
);
    state_t      r_state;
    logic [8:0]  r_cnt;
    logic [7:0]  r_len;
    logic [7:0]  r_tick;
    logic [7:0]  r_prev_tick;
    logic        r_first;
    logic [15:0] r_crc;
    logic [15:0] r_sh;
    logic [23:0] r_gap;
    logic        r_eop;
    logic        r_len_err;
    logic        r_tick_err;
    logic        r_crc_err;
    logic        r_delay;
    logic        r_break;

    logic        w_sop;
    logic        w_done;
    logic [8:0]  w_cnt_inc;
    logic [15:0] w_crc_fold;
    logic [15:0] w_crc;
    logic [7:0]  w_t;
    logic        w_len_err;
    logic        w_crc_err;
    logic        w_tick_err;
    logic        w_good;

    // r_sh holds the two most recent bytes; the older one is folded in as each new byte lands,
    // so at EOP the CRC covers everything but the trailing CRC bytes sitting in r_sh.
    slink_crc16 u_crc (
        .crc_in  (r_crc),
        .data    (r_sh[15:8]),
        .crc_out (w_crc_fold)
    );

    assign w_sop      = rx_valid & rx_sop;
    assign w_done     = rx_valid & ((r_state == ST_IDLE) ? (rx_sop & rx_eop) : (rx_sop | rx_eop));
    assign w_cnt_inc  = r_cnt + {8'd0, ~&r_cnt};
    assign w_crc      = (r_cnt > 9'(OFS_LEN)) ? w_crc_fold : r_crc;
    assign w_t        = (r_state == ST_IDLE) ? rx_data : r_tick;
    assign w_len_err  = rx_sop | (r_state != ST_BODY) | (w_cnt_inc != 9'(r_len) + PKT_OVERHEAD);
    assign w_crc_err  = w_len_err | (w_crc != {r_sh[7:0], rx_data});
    assign w_tick_err = ~r_first & (w_t != r_prev_tick + 8'd1);
    assign w_good     = w_done & ~w_crc_err;

    always_ff @(posedge clk_125m or negedge rst_125m) begin
        if (!rst_125m) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_tick      <= '0;
            r_prev_tick <= '0;
            r_first     <= 1'b1;
            r_crc       <= CRC_INIT;
            r_sh        <= '0;
            r_gap       <= '0;
            r_eop       <= 1'b0;
            r_len_err   <= 1'b0;
            r_tick_err  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_delay     <= 1'b0;
            r_break     <= 1'b1;
        end else begin
            r_gap   <= w_sop ? '0 : r_gap + {23'd0, ~&r_gap};
            r_delay <= w_sop ? 1'b0 : (r_gap > DELAY_MAX);
            r_break <= w_good ? 1'b0 : ((r_gap > BREAK_TIMEOUT) | r_break);
            r_first <= (r_gap > BREAK_TIMEOUT) | (r_first & ~w_done);
            r_eop   <= w_done;
            if (w_done) begin
                r_len_err   <= w_len_err;
                r_crc_err   <= w_crc_err;
                r_tick_err  <= w_tick_err;
                r_prev_tick <= w_t;
            end
            // A SOP+EOP byte arriving mid-packet only closes the aborted packet.
            if (w_sop) begin
                r_state <= rx_eop ? ST_IDLE : ST_TICK;
                r_cnt   <= 9'(OFS_TICK + 1);
                r_tick  <= rx_data;
                r_crc   <= CRC_INIT;
                r_sh    <= {8'h00, rx_data};
            end else if (rx_valid && r_state != ST_IDLE) begin
                r_state <= rx_eop ? ST_IDLE : (r_state == ST_TICK) ? ST_LEN : ST_BODY;
                r_cnt   <= w_cnt_inc;
                r_crc   <= w_crc;
                r_sh    <= {r_sh[7:0], rx_data};
                if (r_state == ST_TICK)
                    r_len <= rx_data;
            end
        end
    end

    assign chn_pkt_eop       = r_eop;
    assign chn_pkt_len_err   = r_len_err;
    assign chn_pkt_tick_err  = r_tick_err;
    assign chn_pkt_crc_err   = r_crc_err;
    assign chn_pkt_delay_err = r_delay;
    assign chn_break_err     = r_break;
endmodule
